// File: rtl/stream_unpacker_if.sv
// Handshake bundle for stream_unpacker: 16-bit word input side and WIDTH-bit chunk output side.
interface stream_unpacker_if #(
    parameter int unsigned WIDTH = 8
);
    logic [15:0]      in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_last;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, out_last
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, out_last
    );
endinterface

// File: rtl/stream_unpacker.sv
// Buffers 16-bit words in a DEPTH-entry FIFO and emits them as 16/WIDTH chunks, LSB chunk first.
module stream_unpacker #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         CLK,
    input  logic                         RST,
    stream_unpacker_if.slave             bus,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);
    localparam int unsigned N  = 16 / WIDTH;
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    typedef enum logic {EMPTY, SEND} state_e;

    state_e          state_q, state_d;
    logic [15:0]     shift_q, shift_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic [15:0]     mem_q [DEPTH];

    logic push;
    logic pop;
    logic last_chunk;

    assign bus.in_ready  = (count_q != CW'(DEPTH));
    assign push          = bus.in_valid && bus.in_ready;
    assign last_chunk    = (idx_q == IW'(N - 1));
    assign bus.out_valid = (state_q == SEND);
    assign bus.out_data  = (state_q == SEND) ? shift_q[WIDTH-1:0] : '0;
    assign bus.out_last  = (state_q == SEND) && last_chunk;
    assign fifo_count    = count_q;

    // Output stage: reloads straight from the FIFO head on the last chunk so words run back-to-back.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (bus.out_ready) begin
                    if (!last_chunk) begin
                        shift_d = shift_q >> WIDTH;
                        idx_d   = idx_q + IW'(1);
                    end else if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        idx_d   = '0;
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= EMPTY;
            shift_q  <= '0;
            idx_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            idx_q    <= idx_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count and pointers alone decide what is readable.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end
endmodule

// File: tb/tb_stream_unpacker.sv
// Exercises stream_unpacker at WIDTH 8, 4 and 16 against a chunk-queue reference model.
module tb_stream_unpacker;
    logic CLK;
    logic RST;
    logic [2:0] fc8, fc4, fc16;

    stream_unpacker_if #(.WIDTH(8))  if8 ();
    stream_unpacker_if #(.WIDTH(4))  if4 ();
    stream_unpacker_if #(.WIDTH(16)) if16 ();

    stream_unpacker #(.WIDTH(8),  .DEPTH(4)) u8  (.CLK(CLK), .RST(RST), .bus(if8.slave),  .fifo_count(fc8));
    stream_unpacker #(.WIDTH(4),  .DEPTH(4)) u4  (.CLK(CLK), .RST(RST), .bus(if4.slave),  .fifo_count(fc4));
    stream_unpacker #(.WIDTH(16), .DEPTH(4)) u16 (.CLK(CLK), .RST(RST), .bus(if16.slave), .fifo_count(fc16));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        int          dut;
        logic [15:0] data;
        logic        last;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic        iv   [3];
    logic [15:0] id   [3];
    logic        ordy [3];
    logic        ov   [3];
    logic        ol   [3];
    logic        ir   [3];
    logic [15:0] od   [3];
    logic [2:0]  fc   [3];
    logic        stalled [3];
    logic [15:0] prev_od [3];
    logic        prev_ol [3];

    function automatic int width_of(input int d);
        return (d == 0) ? 8 : (d == 1) ? 4 : 16;
    endfunction

    task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    // Reference: a word becomes 16/W chunks, chunk k = bits [k*W +: W].
    task automatic model_push(input int d, input logic [15:0] word);
        int w;
        int n;
        int mask;
        exp_t e;
        w    = width_of(d);
        n    = 16 / w;
        mask = (1 << w) - 1;
        for (int k = 0; k < n; k++) begin
            e.dut  = d;
            e.data = 16'((int'(word) >> (k * w)) & mask);
            e.last = (k == n - 1);
            sb.push_back(e);
        end
    endtask

    function automatic int sb_count(input int d);
        int c = 0;
        foreach (sb[i]) if (sb[i].dut == d) c++;
        return c;
    endfunction

    task automatic sample();
        ov[0] = if8.out_valid;  ol[0] = if8.out_last;  ir[0] = if8.in_ready;  od[0] = {8'h0, if8.out_data};  fc[0] = fc8;
        ov[1] = if4.out_valid;  ol[1] = if4.out_last;  ir[1] = if4.in_ready;  od[1] = {12'h0, if4.out_data}; fc[1] = fc4;
        ov[2] = if16.out_valid; ol[2] = if16.out_last; ir[2] = if16.in_ready; od[2] = if16.out_data;         fc[2] = fc16;
    endtask

    task automatic clear_model();
        sb.delete();
        for (int d = 0; d < 3; d++) stalled[d] = 1'b0;
    endtask

    // One cycle: drive, sample mid-cycle, check against the model, advance to just after the edge.
    task automatic step();
        int hit;
        if8.in_valid  = iv[0]; if8.in_data  = id[0]; if8.out_ready  = ordy[0];
        if4.in_valid  = iv[1]; if4.in_data  = id[1]; if4.out_ready  = ordy[1];
        if16.in_valid = iv[2]; if16.in_data = id[2]; if16.out_ready = ordy[2];
        @(negedge CLK);
        sample();
        for (int d = 0; d < 3; d++) begin
            check("in_ready_vs_count", d, ir[d], (fc[d] != 3'd4));
            if (!ov[d]) check("last_low_when_idle", d, ol[d], 1'b0);
            if (stalled[d]) begin
                check("stall_valid", d, ov[d], 1'b1);
                check("stall_data", d, od[d], prev_od[d]);
                check("stall_last", d, ol[d], prev_ol[d]);
            end
            if (ov[d] && ordy[d]) begin
                hit = -1;
                foreach (sb[i]) if (hit < 0 && sb[i].dut == d) hit = i;
                check("chunk_expected", d, (hit >= 0), 1'b1);
                if (hit >= 0) begin
                    check("chunk_data", d, od[d], sb[hit].data);
                    check("chunk_last", d, ol[d], sb[hit].last);
                    sb.delete(hit);
                end
            end
            if (iv[d] && ir[d]) model_push(d, id[d]);
            stalled[d] = ov[d] && !ordy[d];
            prev_od[d] = od[d];
            prev_ol[d] = ol[d];
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet(input int cycles);
        for (int d = 0; d < 3; d++) begin iv[d] = 1'b0; ordy[d] = 1'b1; end
        for (int c = 0; c < cycles; c++) step();
    endtask

    task automatic reset_checks(input string tag);
        sample();
        for (int d = 0; d < 3; d++) begin
            check({tag, "_out_valid"}, d, ov[d], 1'b0);
            check({tag, "_out_last"},  d, ol[d], 1'b0);
            check({tag, "_out_data"},  d, od[d], 16'h0);
            check({tag, "_fifo_count"}, d, fc[d], 3'd0);
            check({tag, "_in_ready"},  d, ir[d], 1'b1);
        end
    endtask

    initial begin
        int nvalid;
        int first;
        int lastv;
        logic [15:0] w0;
        logic [15:0] exp4 [4];

        for (int d = 0; d < 3; d++) begin iv[d] = 1'b0; id[d] = '0; ordy[d] = 1'b0; end
        clear_model();
        if8.in_valid = 1'b0;  if8.in_data = '0;  if8.out_ready = 1'b0;
        if4.in_valid = 1'b0;  if4.in_data = '0;  if4.out_ready = 1'b0;
        if16.in_valid = 1'b0; if16.in_data = '0; if16.out_ready = 1'b0;
        RST = 1'b0;
        #2;
        reset_checks("reset");
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b1;

        // Single word at WIDTH=8: two chunks after one cycle of latency.
        ordy[0] = 1'b1;
        iv[0] = 1'b1; id[0] = 16'hA55A;
        step();
        check("t1_push_ready", 0, ir[0], 1'b1);
        check("t1_idle_at_push", 0, ov[0], 1'b0);
        iv[0] = 1'b0;
        step();
        check("t1_latency_idle", 0, ov[0], 1'b0);
        check("t1_count_one", 0, fc[0], 3'd1);
        step();
        check("t1_c0_valid", 0, ov[0], 1'b1);
        check("t1_c0_data", 0, od[0], 16'h005A);
        check("t1_c0_last", 0, ol[0], 1'b0);
        step();
        check("t1_c1_valid", 0, ov[0], 1'b1);
        check("t1_c1_data", 0, od[0], 16'h00A5);
        check("t1_c1_last", 0, ol[0], 1'b1);
        step();
        check("t1_done_idle", 0, ov[0], 1'b0);
        quiet(3);

        // Fill with the consumer stalled: DEPTH words queued plus one in the output stage.
        ordy[0] = 1'b0;
        w0 = 16'hA010;
        for (int i = 0; i < 6; i++) begin
            iv[0] = 1'b1;
            id[0] = w0 + 16'(i * 16'h0101);
            step();
            if (i < 5) check("t2_accept", 0, ir[0], 1'b1);
        end
        check("t2_full_ready", 0, ir[0], 1'b0);
        check("t2_full_count", 0, fc[0], 3'd4);
        check("t2_head_valid", 0, ov[0], 1'b1);
        check("t2_head_data", 0, od[0], {8'h0, w0[7:0]});
        iv[0] = 1'b0;
        ordy[0] = 1'b1;
        for (int j = 0; j < 10; j++) begin
            step();
            check("t2_drain_valid", 0, ov[0], 1'b1);
        end
        step();
        check("t2_drain_end", 0, ov[0], 1'b0);
        check("t2_drain_empty", 0, sb_count(0), 0);
        quiet(2);

        // Back-to-back words with the consumer always ready: no bubble between words.
        ordy[0] = 1'b1;
        nvalid = 0; first = -1; lastv = -1;
        for (int s = 0; s < 14; s++) begin
            iv[0] = (s < 4);
            id[0] = 16'($urandom);
            step();
            if (ov[0]) begin
                nvalid++;
                if (first < 0) first = s;
                lastv = s;
                check("t3_last_pattern", 0, ol[0], (nvalid % 2 == 0));
            end
        end
        check("t3_chunk_count", 0, nvalid, 8);
        check("t3_first_window", 0, first, 2);
        check("t3_contiguous", 0, lastv - first, 7);
        quiet(2);

        // Consumer toggling ready every cycle: stall stability and ordering checked per step.
        for (int s = 0; s < 14; s++) begin
            iv[0] = (s < 2);
            id[0] = 16'($urandom);
            ordy[0] = s[0];
            step();
        end
        quiet(4);
        check("t4_all_chunks_seen", 0, sb_count(0), 0);

        // WIDTH=4 and WIDTH=16 single words.
        exp4[0] = 16'h4; exp4[1] = 16'h3; exp4[2] = 16'h2; exp4[3] = 16'h1;
        ordy[1] = 1'b1; ordy[2] = 1'b1;
        nvalid = 0; lastv = 0;
        for (int s = 0; s < 8; s++) begin
            iv[1] = (s == 0); id[1] = 16'h1234;
            iv[2] = (s == 0); id[2] = 16'hBEEF;
            step();
            if (ov[1]) begin
                if (nvalid < 4) check("t5_w4_data", 1, od[1], exp4[nvalid]);
                check("t5_w4_last", 1, ol[1], (nvalid == 3));
                nvalid++;
            end
            if (ov[2]) begin
                check("t5_w16_data", 2, od[2], 16'hBEEF);
                check("t5_w16_last", 2, ol[2], 1'b1);
                lastv++;
            end
        end
        check("t5_w4_count", 1, nvalid, 4);
        check("t5_w16_count", 2, lastv, 1);
        quiet(2);

        // Reset in the middle of a word with two more words queued.
        ordy[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[0] = 1'b1; id[0] = 16'hC300 + 16'(i);
            step();
        end
        iv[0] = 1'b0;
        step();
        check("t6_pre_valid", 0, ov[0], 1'b1);
        check("t6_pre_count", 0, fc[0], 3'd2);
        ordy[0] = 1'b1;
        step();
        check("t6_c0_taken_data", 0, od[0], 16'h0000);
        for (int d = 0; d < 3; d++) ordy[d] = 1'b0;
        if8.out_ready = 1'b0;
        #2;
        RST = 1'b0;
        #1;
        reset_checks("t6_reset");
        clear_model();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        for (int d = 0; d < 3; d++) begin iv[d] = 1'b0; ordy[d] = 1'b1; end
        for (int s = 0; s < 4; s++) begin
            step();
            check("t6_no_stale_valid", 0, ov[0], 1'b0);
            check("t6_no_stale_count", 0, fc[0], 3'd0);
        end

        // Randomized traffic on all three widths, then drain.
        for (int s = 0; s < 300; s++) begin
            for (int d = 0; d < 3; d++) begin
                iv[d]   = 1'($urandom_range(0, 1));
                id[d]   = 16'($urandom);
                ordy[d] = ($urandom_range(0, 3) != 0);
            end
            step();
        end
        quiet(40);
        for (int d = 0; d < 3; d++) check("rand_drained", d, sb_count(d), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
